// File: rtl/pspin_stdout_buf.sv
// pspin_stdout_buf: collects 32-bit stdout words from NUM_SRC cluster
// sources through a round-robin arbiter into a first-word-fall-through FIFO
// that the control register block drains one word per pop.
// Optional feature macro: STDOUT_DROP_ON_FULL_EN. When defined, a full FIFO
// keeps accepting and discards words, counting them in drop_count. When
// undefined, a full FIFO backpressures every source and drop_count is 0.
module pspin_stdout_buf #(
  parameter int NUM_SRC   = 2,
  parameter int DEPTH     = 64,
  parameter int CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        s_valid,
  input  logic [32*NUM_SRC-1:0]     s_data,
  output logic [NUM_SRC-1:0]        s_ready,
  input  logic                      stdout_rd_en,
  output logic [31:0]               stdout_dout,
  output logic                      stdout_data_valid,
  output logic [$clog2(DEPTH):0]    fill_level,
  output logic [CNT_WIDTH-1:0]      drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  // Registered state
  logic [PW-1:0]   rr_ptr_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     level_r;
  logic [31:0]     mem [DEPTH];

  // Combinational control
  logic [PW-1:0]   cand_s;
  logic [PW-1:0]   grant_idx_s;
  logic            grant_vld_s;
  logic            full_s;
  logic            accept_ok_s;
  logic            accept_s;
  logic            write_s;
  logic            pop_s;
  logic [31:0]     wr_data_s;

  // Round-robin search: first asserted request at or after the priority pointer
  always_comb begin
    grant_idx_s = rr_ptr_r;
    grant_vld_s = 1'b0;
    cand_s      = rr_ptr_r;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand_s = PW'((int'(rr_ptr_r) + k) % NUM_SRC);
      if (!grant_vld_s && s_valid[cand_s]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = cand_s;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Full comes from the registered level only, so a same-cycle pop never frees a slot
  always_comb begin
    full_s = (level_r == (AW + 1)'(DEPTH));
`ifdef STDOUT_DROP_ON_FULL_EN
    accept_ok_s = 1'b1;
`else
    accept_ok_s = !full_s;
`endif
    accept_s  = grant_vld_s && accept_ok_s && !rst;
    write_s   = accept_s && !full_s;
    pop_s     = stdout_rd_en && (level_r != (AW + 1)'(0)) && !rst;
    wr_data_s = s_data[32*int'(grant_idx_s) +: 32];
  end

  // One-hot ready for the granted source when the word can be taken
  always_comb begin
    s_ready = {NUM_SRC{1'b0}};
    if (accept_s) begin
      s_ready[grant_idx_s] = 1'b1;
    end else begin
      s_ready = {NUM_SRC{1'b0}};
    end
  end

  // Priority pointer advances past the winner on every accept
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= PW'(0);
    end else if (accept_s) begin
      if (grant_idx_s == PW'(NUM_SRC - 1)) begin
        rr_ptr_r <= PW'(0);
      end else begin
        rr_ptr_r <= grant_idx_s + PW'(1);
      end
    end
  end

  // FIFO pointers and level; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      level_r  <= (AW + 1)'(0);
    end else begin
      if (write_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({write_s, pop_s})
        2'b10:   level_r <= level_r + (AW + 1)'(1);
        2'b01:   level_r <= level_r - (AW + 1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Storage array is deliberately not reset; validity is tracked by the level
  always_ff @(posedge clk) begin
    if (write_s) begin
      mem[wr_ptr_r] <= wr_data_s;
    end
  end

`ifdef STDOUT_DROP_ON_FULL_EN
  logic [CNT_WIDTH-1:0] drop_cnt_r;

  // Saturating count of words accepted while full and thrown away
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_r <= CNT_WIDTH'(0);
    end else if (accept_s && full_s && (drop_cnt_r != {CNT_WIDTH{1'b1}})) begin
      drop_cnt_r <= drop_cnt_r + CNT_WIDTH'(1);
    end
  end

  assign drop_count = drop_cnt_r;
`else
  assign drop_count = CNT_WIDTH'(0);
`endif

  assign stdout_dout       = mem[rd_ptr_r];
  assign stdout_data_valid = (level_r != (AW + 1)'(0)) && !rst;
  assign fill_level        = level_r;

endmodule
